if_scratch_writer: RTL and testbench
====================================

// Module: if_scratch_writer
// PURPOSE
//  Producer side of the IF circular scratchpad: accepts IF words from a valid/ready stream and writes them
//  into the CELL_NUMS_IF-entry ring, publishing write_addr_if to the convolution read-side checker.
//  Space is reclaimed only when the checker advances write_start; the ring is never overwritten.
//  One job = start pulse + total_words; done pulses after the last word is written.
// PARAMETERS
//  IF_CELL_SIZE     8   width of one IF word
//  IF_ADDRESS_SIZE  8   scratchpad address width
//  CELL_NUMS_IF     8   ring depth N (any value 2..2^IF_ADDRESS_SIZE, not necessarily a power of two)
//  COUNT_SIZE       16  width of the job word counter
// PORTS
//  clk            in   1                rising-edge clock
//  rst            in   1                synchronous, active-high reset
//  start          in   1                job start pulse (honoured only in IDLE)
//  total_words    in   COUNT_SIZE       words in the job, sampled with start
//  in_data        in   IF_CELL_SIZE     incoming IF word
//  in_valid       in   1                in_data valid
//  in_ready       out  1                writer can accept in_data this cycle
//  write_start    in   IF_ADDRESS_SIZE  oldest slot still needed by the reader (release pointer)
//  write_addr_if  out  IF_ADDRESS_SIZE  next free slot (to checker)
//  scratch_wen    out  1                scratchpad write enable (registered)
//  scratch_waddr  out  IF_ADDRESS_SIZE  scratchpad write address (registered)
//  scratch_wdata  out  IF_CELL_SIZE     scratchpad write data (registered)
//  full           out  1                (write_addr_if+1) wrap N == write_start
//  occupancy      out  IF_ADDRESS_SIZE  (write_addr_if - write_start) mod N
//  busy           out  1                state == FILL
//  done           out  1                one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: state=IDLE, write_addr_if=0, count=0, scratch_wen=0, scratch_waddr=0, scratch_wdata=0, done=0.
//   Reset mid-job aborts the job immediately; pending write is dropped; any in-flight stream word is not taken.
//  FSM IDLE/FILL/DONE:
//   IDLE: in_ready=0. start & total_words!=0 -> FILL, count<=total_words. start & total_words==0 -> DONE.
//   FILL: in_ready = ~full. Transfer = in_valid & in_ready. On transfer: write_addr_if advances by 1
//    (N-1 wraps to 0 by compare, no modulo), count-1; count reaching 0 -> DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. start outside IDLE is ignored.
//  Write port: latency 1; cycle after a transfer scratch_wen=1, waddr=pre-increment pointer, wdata=in_data.
//   scratch_wen=0 on all other cycles; waddr/wdata hold last value.
//  full/occupancy combinational from current write_addr_if and write_start; one slot always left empty
//   (max occupancy N-1), matching the checker's scratch_write_en rule.
//  write_start changing in the same cycle as a transfer: full uses the current-cycle write_start; a release
//   that un-fills the ring enables the transfer in that same cycle.
//  write_addr_if persists across jobs (ring is continuous); only rst returns it to 0.
//  in_valid without in_ready: no state change, word must be held by source (standard valid/ready).
// STRUCTURE
//  Shared include/package (cad_scratch_defs): FSM state encodings, ring-increment and ring-distance functions
//   used by both this writer and the checker.
//  One sub-module: circ_ptr_inc (ptr, N) -> ptr==N-1 ? 0 : ptr+1; reused for the filter-side writer.
//  Rest is a single always block FSM + counter + registered write port (~150-200 lines).
// TESTING (N=8)
//  rst; start, total_words=5, in_valid=1 constant, write_start=0 -> 5 writes to addr 0..4, write_addr_if=5, done 1 cycle after 5th transfer.
//  write_start=0, total_words=10 -> in_ready drops after 7 writes (write_addr_if=7, full=1, occupancy=7); set write_start=3 -> 3 more written at 7,0,1, done.
//  write_addr_if=6, write_start=6, total_words=4 -> writes at 6,7,0,1 (wrap), write_addr_if=2, occupancy=4.
//  full=1, same cycle write_start advances by 1 with in_valid=1 -> transfer accepted that cycle, full stays 1 next cycle.
//  start with total_words=0 -> no scratch_wen, done pulses next cycle, back to IDLE; start during FILL ignored.
//  rst asserted mid-job after 2 transfers -> next cycle all outputs at reset values, scratch_wen=0, in_ready=0.

Source files
------------

// File: rtl/if_scratch_writer_pkg.sv
// Shared definitions for the IF scratchpad writer and its read-side checker:
// FSM state encodings, default geometry, and ring-pointer helper functions.
package if_scratch_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } writer_state_t;

    localparam int DEF_IF_CELL_SIZE    = 8;
    localparam int DEF_IF_ADDRESS_SIZE = 8;
    localparam int DEF_CELL_NUMS_IF    = 8;
    localparam int DEF_COUNT_SIZE      = 16;

    // Next slot on a ring of 'depth' entries; the wrap is a compare, not a
    // modulo, so the depth does not have to be a power of two.
    function automatic logic [15:0] ringInc(input logic [15:0] ptr,
                                            input logic [15:0] depth);
        return (ptr == depth - 16'd1) ? 16'd0 : ptr + 16'd1;
    endfunction

    // Number of occupied slots between the release pointer (tail) and the
    // write pointer (head) on a ring of 'depth' entries.
    function automatic logic [15:0] ringDist(input logic [15:0] head,
                                             input logic [15:0] tail,
                                             input logic [15:0] depth);
        return (head >= tail) ? (head - tail) : (head + depth - tail);
    endfunction

endpackage

// File: rtl/if_scratch_writer_circ_ptr_inc.sv
// Circular pointer increment: ptr == DEPTH-1 wraps to 0, otherwise ptr+1.
// Shared between the IF writer and the filter-side writer.
module circ_ptr_inc #(
    parameter int PTR_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic [PTR_WIDTH-1:0] i_ptr,
    output logic [PTR_WIDTH-1:0] o_next
);

    // Wrap by comparison so non-power-of-two depths work.
    always_comb begin
        o_next = i_ptr + PTR_WIDTH'(1);
        if (i_ptr == PTR_WIDTH'(DEPTH - 1)) begin
            o_next = '0;
        end
    end

endmodule

// File: rtl/if_scratch_writer.sv
// Producer side of the IF circular scratchpad. Accepts words from a
// valid/ready stream and writes them into the ring, never overwriting slots
// the reader has not yet released through write_start.
module if_scratch_writer
    import if_scratch_writer_pkg::*;
#(
    parameter int IF_CELL_SIZE    = DEF_IF_CELL_SIZE,
    parameter int IF_ADDRESS_SIZE = DEF_IF_ADDRESS_SIZE,
    parameter int CELL_NUMS_IF    = DEF_CELL_NUMS_IF,
    parameter int COUNT_SIZE      = DEF_COUNT_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [COUNT_SIZE-1:0]      total_words,
    input  logic [IF_CELL_SIZE-1:0]    in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IF_ADDRESS_SIZE-1:0] write_start,
    output logic [IF_ADDRESS_SIZE-1:0] write_addr_if,
    output logic                       scratch_wen,
    output logic [IF_ADDRESS_SIZE-1:0] scratch_waddr,
    output logic [IF_CELL_SIZE-1:0]    scratch_wdata,
    output logic                       full,
    output logic [IF_ADDRESS_SIZE-1:0] occupancy,
    output logic                       busy,
    output logic                       done
);

    writer_state_t r_state;
    writer_state_t w_stateNext;

    logic [IF_ADDRESS_SIZE-1:0] r_writeAddr;
    logic [IF_ADDRESS_SIZE-1:0] w_writeAddrNext;
    logic [IF_ADDRESS_SIZE-1:0] w_nextAddr;
    logic [COUNT_SIZE-1:0]      r_count;
    logic [COUNT_SIZE-1:0]      w_countNext;

    logic                       r_wen;
    logic [IF_ADDRESS_SIZE-1:0] r_waddr;
    logic [IF_CELL_SIZE-1:0]    r_wdata;

    logic                       w_full;
    logic                       w_inReady;
    logic                       w_transfer;

    circ_ptr_inc #(
        .PTR_WIDTH (IF_ADDRESS_SIZE),
        .DEPTH     (CELL_NUMS_IF)
    ) u_ptrInc (
        .i_ptr  (r_writeAddr),
        .o_next (w_nextAddr)
    );

    // One slot is always kept empty: the ring is full when the next write
    // slot would land on the oldest slot the reader still needs. Uses the
    // live write_start so a same-cycle release can immediately unblock.
    assign w_full = (w_nextAddr == write_start);

    // Occupancy is the ring distance from the release pointer to the head.
    assign occupancy = IF_ADDRESS_SIZE'(ringDist(16'(r_writeAddr),
                                                 16'(write_start),
                                                 16'(CELL_NUMS_IF)));

    assign full          = w_full;
    assign in_ready      = w_inReady;
    assign write_addr_if = r_writeAddr;
    assign scratch_wen   = r_wen;
    assign scratch_waddr = r_waddr;
    assign scratch_wdata = r_wdata;
    assign busy          = (r_state == ST_FILL);
    assign done          = (r_state == ST_DONE);

    // Next-state, handshake and pointer/counter update for the job FSM.
    always_comb begin
        w_stateNext     = r_state;
        w_writeAddrNext = r_writeAddr;
        w_countNext     = r_count;
        w_inReady       = 1'b0;
        w_transfer      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (total_words != '0) begin
                        w_stateNext = ST_FILL;
                        w_countNext = total_words;
                    end else begin
                        w_stateNext = ST_DONE;
                    end
                end
            end
            ST_FILL: begin
                w_inReady  = ~w_full;
                w_transfer = in_valid & w_inReady;
                if (w_transfer) begin
                    w_writeAddrNext = w_nextAddr;
                    w_countNext     = r_count - COUNT_SIZE'(1);
                    if (r_count == COUNT_SIZE'(1)) begin
                        w_stateNext = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State, pointer and counter registers plus the one-cycle-delayed
    // scratchpad write port; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_writeAddr <= '0;
            r_count     <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_writeAddr <= w_writeAddrNext;
            r_count     <= w_countNext;
            r_wen       <= w_transfer;
            if (w_transfer) begin
                r_waddr <= r_writeAddr;
                r_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_if_scratch_writer.sv
// Directed testbench for the IF scratchpad writer with a ring depth of 8.
module tb_if_scratch_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] total_words;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  write_start;
    logic [7:0]  write_addr_if;
    logic        scratch_wen;
    logic [7:0]  scratch_waddr;
    logic [7:0]  scratch_wdata;
    logic        full;
    logic [7:0]  occupancy;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int failCount  = 0;

    if_scratch_writer #(
        .IF_CELL_SIZE    (8),
        .IF_ADDRESS_SIZE (8),
        .CELL_NUMS_IF    (8),
        .COUNT_SIZE      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .total_words   (total_words),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_start   (write_start),
        .write_addr_if (write_addr_if),
        .scratch_wen   (scratch_wen),
        .scratch_waddr (scratch_waddr),
        .scratch_wdata (scratch_wdata),
        .full          (full),
        .occupancy     (occupancy),
        .busy          (busy),
        .done          (done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive all stream/control inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic iStart, input logic [15:0] iTotal,
                                 input logic iValid, input logic [7:0] iData,
                                 input logic [7:0] iWs);
        start       = iStart;
        total_words = iTotal;
        in_valid    = iValid;
        in_data     = iData;
        write_start = iWs;
        #1;
    endtask

    // Advance past the next rising edge so registered outputs are stable.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        #1;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        logic [7:0] expAddr [3];

        rst = 1'b1;
        start = 1'b0;
        total_words = '0;
        in_data = '0;
        in_valid = 1'b0;
        write_start = '0;
        stepClock();
        stepClock();
        rst = 1'b0;
        #1;

        $display("[TB] reset values");
        checkOutput("rst_waddr_if", 32'(write_addr_if), 0);
        checkOutput("rst_wen", 32'(scratch_wen), 0);
        checkOutput("rst_waddr", 32'(scratch_waddr), 0);
        checkOutput("rst_wdata", 32'(scratch_wdata), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_occ", 32'(occupancy), 0);
        checkOutput("rst_full", 32'(full), 0);

        $display("[TB] five-word job");
        applyStimulus(1'b1, 16'd5, 1'b1, 8'hA0, 8'd0);
        stepClock();
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_first_wen", 32'(scratch_wen), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'd5, 1'b1, 8'(8'hA0 + i), 8'd0);
            checkOutput("t1_ready", 32'(in_ready), 1);
            stepClock();
            checkOutput("t1_wen", 32'(scratch_wen), 1);
            checkOutput("t1_waddr", 32'(scratch_waddr), 32'(i));
            checkOutput("t1_wdata", 32'(scratch_wdata), 32'(8'hA0 + i));
            if (i < 4) checkOutput("t1_done_early", 32'(done), 0);
        end
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_waddr_if", 32'(write_addr_if), 5);
        checkOutput("t1_busy_end", 32'(busy), 0);
        checkOutput("t1_ready_done", 32'(in_ready), 0);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd0);
        stepClock();
        checkOutput("t1_done_pulse", 32'(done), 0);
        checkOutput("t1_wen_off", 32'(scratch_wen), 0);
        checkOutput("t1_waddr_hold", 32'(scratch_waddr), 4);
        checkOutput("t1_wdata_hold", 32'(scratch_wdata), 32'h A4);

        $display("[TB] fill until full then release");
        doReset();
        applyStimulus(1'b1, 16'd10, 1'b1, 8'h10, 8'd0);
        stepClock();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 16'd10, 1'b1, 8'(8'h10 + i), 8'd0);
            stepClock();
            checkOutput("t2_waddr", 32'(scratch_waddr), 32'(i));
        end
        checkOutput("t2_waddr_if", 32'(write_addr_if), 7);
        checkOutput("t2_full", 32'(full), 1);
        checkOutput("t2_occ", 32'(occupancy), 7);
        checkOutput("t2_ready_low", 32'(in_ready), 0);
        checkOutput("t2_busy", 32'(busy), 1);
        stepClock();
        checkOutput("t2_stall_wen", 32'(scratch_wen), 0);
        checkOutput("t2_stall_addr", 32'(write_addr_if), 7);
        applyStimulus(1'b0, 16'd10, 1'b1, 8'h20, 8'd3);
        checkOutput("t2_ready_rel", 32'(in_ready), 1);
        checkOutput("t2_full_rel", 32'(full), 0);
        checkOutput("t2_occ_rel", 32'(occupancy), 4);
        expAddr[0] = 8'd7;
        expAddr[1] = 8'd0;
        expAddr[2] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'd10, 1'b1, 8'(8'h20 + i), 8'd3);
            stepClock();
            checkOutput("t2_wen", 32'(scratch_wen), 1);
            checkOutput("t2_waddr_wrap", 32'(scratch_waddr), 32'(expAddr[i]));
            checkOutput("t2_wdata", 32'(scratch_wdata), 32'(8'h20 + i));
        end
        checkOutput("t2_done", 32'(done), 1);
        checkOutput("t2_waddr_if_end", 32'(write_addr_if), 2);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd3);
        stepClock();

        $display("[TB] wrap from slot 6");
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd0);
        doReset();
        applyStimulus(1'b1, 16'd6, 1'b1, 8'h30, 8'd0);
        stepClock();
        applyStimulus(1'b0, 16'd6, 1'b1, 8'h30, 8'd0);
        for (int i = 0; i < 6; i++) stepClock();
        checkOutput("t3_pre_done", 32'(done), 1);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd0);
        stepClock();
        checkOutput("t3_pre_addr", 32'(write_addr_if), 6);
        applyStimulus(1'b1, 16'd4, 1'b1, 8'h40, 8'd6);
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd4, 1'b1, 8'(8'h40 + i), 8'd6);
            stepClock();
            checkOutput("t3_waddr", 32'(scratch_waddr), 32'((6 + i) % 8));
            checkOutput("t3_wdata", 32'(scratch_wdata), 32'(8'h40 + i));
        end
        checkOutput("t3_waddr_if", 32'(write_addr_if), 2);
        checkOutput("t3_occ", 32'(occupancy), 4);
        checkOutput("t3_done", 32'(done), 1);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd6);
        stepClock();

        $display("[TB] same-cycle release while full");
        applyStimulus(1'b1, 16'd4, 1'b1, 8'h50, 8'd6);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'd4, 1'b1, 8'(8'h50 + i), 8'd6);
            stepClock();
            checkOutput("t4_waddr", 32'(scratch_waddr), 32'(2 + i));
        end
        checkOutput("t4_addr_full", 32'(write_addr_if), 5);
        checkOutput("t4_full", 32'(full), 1);
        checkOutput("t4_ready_low", 32'(in_ready), 0);
        applyStimulus(1'b0, 16'd4, 1'b1, 8'h53, 8'd7);
        checkOutput("t4_ready_rel", 32'(in_ready), 1);
        stepClock();
        checkOutput("t4_wen", 32'(scratch_wen), 1);
        checkOutput("t4_waddr_rel", 32'(scratch_waddr), 5);
        checkOutput("t4_wdata_rel", 32'(scratch_wdata), 32'h53);
        checkOutput("t4_addr_after", 32'(write_addr_if), 6);
        checkOutput("t4_full_after", 32'(full), 1);
        checkOutput("t4_done", 32'(done), 1);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd7);
        stepClock();

        $display("[TB] zero-length job and start during fill");
        applyStimulus(1'b1, 16'd0, 1'b1, 8'h60, 8'd6);
        stepClock();
        checkOutput("t5_zero_done", 32'(done), 1);
        checkOutput("t5_zero_wen", 32'(scratch_wen), 0);
        checkOutput("t5_zero_busy", 32'(busy), 0);
        checkOutput("t5_zero_addr", 32'(write_addr_if), 6);
        applyStimulus(1'b0, 16'd0, 1'b1, 8'h60, 8'd6);
        stepClock();
        checkOutput("t5_zero_idle", 32'(done), 0);
        checkOutput("t5_zero_wen2", 32'(scratch_wen), 0);
        checkOutput("t5_zero_ready", 32'(in_ready), 0);
        applyStimulus(1'b1, 16'd2, 1'b0, 8'h70, 8'd6);
        stepClock();
        checkOutput("t5_busy", 32'(busy), 1);
        applyStimulus(1'b1, 16'd9, 1'b0, 8'h70, 8'd6);
        stepClock();
        checkOutput("t5_busy_ign", 32'(busy), 1);
        checkOutput("t5_wen_ign", 32'(scratch_wen), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'd9, 1'b1, 8'(8'h70 + i), 8'd6);
            stepClock();
            checkOutput("t5_waddr", 32'(scratch_waddr), 32'(6 + i));
        end
        checkOutput("t5_done", 32'(done), 1);
        checkOutput("t5_addr_wrap", 32'(write_addr_if), 0);
        applyStimulus(1'b0, 16'd0, 1'b0, 8'h00, 8'd0);
        stepClock();

        $display("[TB] reset mid-job");
        applyStimulus(1'b1, 16'd5, 1'b1, 8'h80, 8'd0);
        stepClock();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'd5, 1'b1, 8'(8'h80 + i), 8'd0);
            stepClock();
        end
        checkOutput("t6_pre_addr", 32'(write_addr_if), 2);
        applyStimulus(1'b0, 16'd5, 1'b1, 8'h82, 8'd0);
        checkOutput("t6_pre_ready", 32'(in_ready), 1);
        rst = 1'b1;
        stepClock();
        checkOutput("t6_addr", 32'(write_addr_if), 0);
        checkOutput("t6_wen", 32'(scratch_wen), 0);
        checkOutput("t6_waddr", 32'(scratch_waddr), 0);
        checkOutput("t6_wdata", 32'(scratch_wdata), 0);
        checkOutput("t6_done", 32'(done), 0);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_ready", 32'(in_ready), 0);
        rst = 1'b0;
        stepClock();
        checkOutput("t6_idle_ready", 32'(in_ready), 0);
        checkOutput("t6_idle_addr", 32'(write_addr_if), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
